// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, shifts one
// command byte out on the device clock and reports whether the device acknowledged it.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] i_cmd_data,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_dat_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_timeout
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_clk_sync;
    logic [1:0]         r_dat_sync;
    logic               r_clk_prev;
    logic [INH_W-1:0]   r_inh_cnt;
    logic [19:0]        r_to_cnt;
    logic [3:0]         r_bit_cnt;
    logic [8:0]         r_shift;
    logic               r_ack_bit;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic               r_done;
    logic               r_ack_err;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [INH_W-1:0]   w_inh_cnt_nxt;
    logic [19:0]        w_to_cnt_nxt;
    logic [3:0]         w_bit_cnt_nxt;
    logic [8:0]         w_shift_nxt;
    logic               w_ack_bit_nxt;
    logic               w_clk_oe_nxt;
    logic               w_dat_oe_nxt;
    logic               w_done_nxt;
    logic               w_ack_err_nxt;
    logic               w_timeout_nxt;

    logic               w_clk_s;
    logic               w_dat_s;
    logic               w_clk_fe;
    logic [3:0]         w_bit_num;
    logic               w_to_expired;

    // Synchronizers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat_in};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_clk_s      = r_clk_sync[1];
    assign w_dat_s      = r_dat_sync[1];
    assign w_clk_fe     = r_clk_prev & ~w_clk_s;
    assign w_bit_num    = r_bit_cnt + 4'd1;
    assign w_to_expired = (r_to_cnt == TO_LAST);

    always_ff @(posedge CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ack_bit <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_inh_cnt <= w_inh_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ack_bit <= w_ack_bit_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_done    <= w_done_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Line enables and pulses are decoded for the state being entered, so they are registered.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_state_nxt   = r_state;
        w_inh_cnt_nxt = r_inh_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ack_bit_nxt = r_ack_bit;
        w_clk_oe_nxt  = 1'b0;
        w_dat_oe_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_ack_err_nxt = 1'b0;
        w_timeout_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_state_nxt   = S_INHIBIT;
                    w_shift_nxt   = {~^i_cmd_data, i_cmd_data};
                    w_inh_cnt_nxt = '0;
                    w_clk_oe_nxt  = 1'b1;
                end
            end
            S_INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt  = S_REQ;
                    w_dat_oe_nxt = 1'b1;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + INH_ONE;
                end
            end
            S_REQ: begin
                w_state_nxt   = S_SHIFT;
                w_to_cnt_nxt  = '0;
                w_bit_cnt_nxt = '0;
                w_dat_oe_nxt  = 1'b1;
            end
            S_SHIFT: begin
                w_dat_oe_nxt = r_dat_oe;
                if (w_to_expired) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                    w_dat_oe_nxt  = 1'b0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 20'd1;
                    if (w_clk_fe) begin
                        w_bit_cnt_nxt = w_bit_num;
                        if (w_bit_num <= 4'd9) begin
                            // Data LSB first, then parity; a 1 bit means release the line.
                            w_dat_oe_nxt = ~r_shift[0];
                            w_shift_nxt  = {1'b0, r_shift[8:1]};
                        end else if (w_bit_num == 4'd10) begin
                            w_dat_oe_nxt = 1'b0;
                        end else begin
                            w_ack_bit_nxt = w_dat_s;
                            w_dat_oe_nxt  = 1'b0;
                            w_state_nxt   = S_WAIT_IDLE;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_to_expired) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 20'd1;
                    if (w_clk_s && w_dat_s) begin
                        w_state_nxt   = S_DONE;
                        w_done_nxt    = 1'b1;
                        w_ack_err_nxt = r_ack_bit;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_ps2_clk_oe = r_clk_oe;
    assign o_ps2_dat_oe = r_dat_oe;
    assign o_done       = r_done;
    assign o_ack_err    = r_ack_err;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-collector device model clocks bytes out of the
// host while a compare process checks the line enables against a bit-level frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 6000;
    localparam int TO      = 2000;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       clk_oe;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    logic       dev_clk;
    logic       dev_dat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic exp_on = 1'b0;
    logic exp_clk_oe = 1'b0;
    logic exp_dat_oe = 1'b0;
    logic armed = 1'b0;

    int   n_done = 0;
    int   n_to = 0;
    logic last_ack = 1'b0;
    int   done_cyc = 0;
    int   rise_cyc = 0;
    logic prev_clk_oe = 1'b0;
    logic watch_ready = 1'b0;
    int   watch_base = 0;
    int   ready_seen = 0;

    // Open-collector bus: a line is low if either side pulls it.
    assign ps2_clk_in = dev_clk & ~clk_oe;
    assign ps2_dat_in = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .i_cmd_data  (cmd_data),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_ps2_clk_in(ps2_clk_in),
        .i_ps2_dat_in(ps2_dat_in),
        .o_ps2_clk_oe(clk_oe),
        .o_ps2_dat_oe(dat_oe),
        .o_busy      (busy),
        .o_done      (done),
        .o_ack_err   (ack_err),
        .o_timeout   (timeout)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: enable level the host must hold after device falling edge k.
    function automatic logic model_dat_oe(input logic [7:0] d, input int k);
        logic parity;
        parity = ~^d;
        if (k >= 1 && k <= 8) return ~d[k-1];
        if (k == 9) return ~parity;
        return 1'b0;
    endfunction

    // Compare and pulse monitor, sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (armed) begin
            if (exp_on) begin
                check("clk_oe_model", clk_oe, exp_clk_oe);
                check("dat_oe_model", dat_oe, exp_dat_oe);
            end
            check("ack_err_outside_done", ack_err & ~done, 0);
            if (watch_ready && n_done == watch_base && cmd_ready)
                ready_seen <= ready_seen + 1;
            if (done) begin
                n_done   <= n_done + 1;
                last_ack <= ack_err;
                done_cyc <= cyc;
            end
            if (timeout) n_to <= n_to + 1;
            if (clk_oe && !prev_clk_oe) rise_cyc <= cyc;
        end
        prev_clk_oe <= clk_oe;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic accept(input logic [7:0] d, input bit hold);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_accept", cmd_ready, 1);
        cmd_data  = d;
        cmd_valid = 1'b1;
        tick();
        if (!hold) cmd_valid = 1'b0;
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic measure_inhibit();
        int n = 0;
        int dat_rise = -1;
        while (clk_oe && n < INHIBIT + 100) begin
            n++;
            if (dat_oe && dat_rise < 0) dat_rise = n;
            tick();
        end
        check("clk_oe_high_cycles", n, INHIBIT + 1);
        check("dat_oe_rise_position", dat_rise, INHIBIT + 1);
        check("start_bit_lines", {clk_oe, dat_oe}, 2'b01);
    endtask

    task automatic wait_shift();
        int n = 0;
        while (!(dat_oe && !clk_oe) && n < INHIBIT + 100) begin
            tick();
            n++;
        end
        check("shift_entry", {clk_oe, dat_oe}, 2'b01);
    endtask

    task automatic dev_send(input logic [7:0] d, input logic ack, input int n_fe,
                            output logic [9:0] obs);
        obs = '0;
        exp_clk_oe = 1'b0;
        exp_dat_oe = 1'b1;
        exp_on     = 1'b1;
        repeat (5) tick();
        for (int k = 1; k <= n_fe; k++) begin
            exp_on = 1'b0;
            if (k == 11) begin
                dev_dat = ack ? 1'b0 : 1'b1;
                repeat (3) tick();
            end
            dev_clk = 1'b0;
            repeat (5) tick();
            if (k <= 10) begin
                exp_dat_oe = model_dat_oe(d, k);
                exp_on     = 1'b1;
            end
            repeat (5) tick();
            if (k <= 10) obs[k-1] = dat_oe;
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
            repeat (10) tick();
        end
        exp_on = 1'b0;
    endtask

    task automatic wait_done(input int base, input logic exp_ack);
        int n = 0;
        while (n_done == base && n < 200) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("done_pulse_count", n_done, base + 1);
        check("ack_err_value", last_ack, exp_ack);
    endtask

    initial begin
        logic [9:0] obs;
        int d0;
        int t0;
        int n;

        resetn    = 1'b0;
        cmd_data  = 8'h00;
        cmd_valid = 1'b0;
        dev_clk   = 1'b1;
        dev_dat   = 1'b1;

        // Reset
        repeat (2) tick();
        resetn = 1'b1;
        armed  = 1'b1;
        check("reset_outputs", {clk_oe, dat_oe, busy, cmd_ready, done, ack_err, timeout},
              7'b0001000);
        repeat (20) tick();
        check("reset_no_pulses", {n_done[7:0], n_to[7:0]}, 16'h0000);

        // 0xED, device acks
        d0 = n_done; t0 = n_to;
        accept(8'hED, 1'b0);
        measure_inhibit();
        dev_send(8'hED, 1'b1, 11, obs);
        check("ed_frame_literal", obs, 10'h012);
        wait_done(d0, 1'b0);
        check("ed_no_timeout", n_to, t0);

        // 0x00, device leaves DAT high on the ack bit
        d0 = n_done;
        accept(8'h00, 1'b0);
        measure_inhibit();
        dev_send(8'h00, 1'b0, 11, obs);
        check("zero_frame_literal", obs, 10'h0FF);
        wait_done(d0, 1'b1);

        // Device never clocks after the request
        d0 = n_done; t0 = n_to;
        accept(8'h5A, 1'b0);
        measure_inhibit();
        n = 0;
        while (!timeout && n < TO + 100) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TO);
        check("timeout_lines_released", {clk_oe, dat_oe}, 2'b00);
        tick();
        check("ready_after_timeout", {cmd_ready, timeout}, 2'b10);
        repeat (5) tick();
        check("timeout_pulse_count", n_to, t0 + 1);
        check("timeout_no_done", n_done, d0);

        // 0xFF held on cmd_valid throughout a 0xED transfer
        d0 = n_done;
        accept(8'hED, 1'b1);
        cmd_data    = 8'hFF;
        watch_base  = n_done;
        watch_ready = 1'b1;
        measure_inhibit();
        dev_send(8'hED, 1'b1, 11, obs);
        check("held_ed_frame_literal", obs, 10'h012);
        wait_done(d0, 1'b0);
        watch_ready = 1'b0;
        check("ready_low_during_transfer", ready_seen, 0);
        wait_shift();
        cmd_valid = 1'b0;
        check("ff_accept_first_idle", rise_cyc - done_cyc, 2);
        d0 = n_done;
        dev_send(8'hFF, 1'b1, 11, obs);
        check("ff_frame_literal", obs, 10'h000);
        wait_done(d0, 1'b0);

        // Reset after the fourth device clock
        d0 = n_done; t0 = n_to;
        accept(8'h00, 1'b0);
        measure_inhibit();
        dev_send(8'h00, 1'b1, 4, obs);
        check("partial_frame_bits", obs[3:0], 4'hF);
        resetn = 1'b0;
        tick();
        check("midreset_outputs", {clk_oe, dat_oe, busy, cmd_ready}, 4'b0001);
        tick();
        resetn = 1'b1;
        repeat (TO + 500) tick();
        check("midreset_no_done", n_done, d0);
        check("midreset_no_timeout", n_to, t0);
        check("midreset_idle", {busy, cmd_ready, clk_oe, dat_oe}, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
